sw_sequencer: RTL and testbench
===============================

SW_SEQUENCER -- requirements
Module: sw_sequencer

Interface
REQ-001 Parameter N_PROFILE, default 4: number of stored time-group profiles (power of 2, 2..8).
REQ-002 Parameter GAP_CYCLES, default 4: sw_req low time between steps; values below 3 are clamped to 3.
REQ-003 Parameter ACK_TIMEOUT, default 1048576: maximum cycles to wait for sw_ack.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port enable, input, 1: sequencer arm; when low, triggers are ignored.
REQ-007 Port trig, input, 1: one-cycle sequence-start pulse.
REQ-008 Port cfg_num_steps, input, log2(N_PROFILE)+1: steps per sequence; 0 is treated as 1; values above N_PROFILE are clamped to N_PROFILE.
REQ-009 Port cfg_wr_en, input, 1: table write strobe.
REQ-010 Port cfg_wr_addr, input, log2(N_PROFILE)+5: {profile, slot}; slot range 0..23.
REQ-011 Port cfg_wr_data, input, 14: switch-off time in cycles for that slot.
REQ-012 Port sw_time_group, output, 336: 24 x 14-bit fields; slot i occupies bits [14i+13:14i].
REQ-013 Port sw_req, output, 1: level request to the switch driver.
REQ-014 Port sw_ack, input, 1: one-cycle completion pulse from the switch driver.
REQ-015 Port busy, output, 1: high in any state other than IDLE.
REQ-016 Port step_idx, output, log2(N_PROFILE): profile currently driven.
REQ-017 Port seq_done, output, 1: one-cycle pulse when a sequence completes normally.
REQ-018 Port err_timeout, output, 1: sticky flag; cleared only by reset.
REQ-019 Port trig_miss_cnt, output, 16: count of dropped triggers; saturates at 0xFFFF.

Function
REQ-020 FSM states: IDLE, REQ, GAP.
- Transitions: IDLE->REQ on trig & enable; REQ->GAP on sw_ack; GAP->REQ or IDLE after GAP_CYCLES.
REQ-021 Trig sampled in IDLE at cycle N: step_idx=0, sw_time_group loaded from profile 0, sw_req=1 at cycle N+1.
REQ-022 sw_time_group is latched at each REQ entry.
- Held stable until the next REQ entry.
- Table writes never disturb an in-flight step.
REQ-023 sw_req stays high through the REQ state.
- sw_ack sampled high in REQ: sw_req=0 next cycle, enter GAP.
REQ-024 GAP lasts exactly GAP_CYCLES cycles with sw_req low.
- Then, if step_idx < steps-1 and enable is high: step_idx+1, new group latched, sw_req=1.
- Otherwise: seq_done pulses one cycle, enter IDLE.
REQ-025 enable low mid-sequence: the current step finishes, the remaining steps are skipped, seq_done still pulses.
REQ-026 sw_ack outside REQ is ignored.
REQ-027 Trig while busy, or while enable is low: trig_miss_cnt+1 (saturating); the trigger is otherwise ignored.
REQ-028 Trig coinciding with the seq_done cycle is a miss.
REQ-029 Ack timeout: REQ lasting ACK_TIMEOUT cycles without sw_ack.
- err_timeout=1, sw_req=0, enter GAP.
- Sequence then ends as in REQ-024, with no seq_done pulse.
REQ-030 cfg_wr_en with slot >= 24 is ignored.
- Any accepted write takes effect the next cycle, in every state.

Reset
REQ-031 rst_n low forces, asynchronously:
- IDLE; sw_req=0; busy=0; step_idx=0; seq_done=0; err_timeout=0; trig_miss_cnt=0; sw_time_group=0.
- All table entries = 0; timeout and gap counters = 0.
REQ-032 Reset asserted mid-sequence drops sw_req immediately; there is no completion pulse.

Structure
REQ-033 Package sw_seq_pkg holds:
- FSM state type.
- Constants N_SW=24, SW_TW=14, GROUP_W=336, GAP_MIN=3.
REQ-034 Sub-module sw_time_table holds the profile storage: write port, one read port selected by profile index.
REQ-035 Sub-module read data is registered into sw_time_group by sw_sequencer.

Verification
REQ-036 Load profile 0 slot 5 = 0x0123, steps=1, trig.
- sw_req rises the next cycle with sw_time_group[83:70]=0x0123.
- Ack after 10 cycles -> sw_req falls, seq_done pulses 4 cycles later.
REQ-037 steps=3, three distinct profiles, ack each after 20 cycles.
- step_idx goes 0,1,2.
- Each sw_req low gap is exactly 4 cycles.
- One seq_done pulse.
REQ-038 ACK_TIMEOUT=64, never ack.
- sw_req drops after 64 cycles; err_timeout=1 and stays 1; no seq_done.
REQ-039 Three trigs while busy, then 0x10000 trigs with enable=0.
- trig_miss_cnt=3 after the busy trigs, 0xFFFF after the disabled trigs.
REQ-040 Write profile 0 during its own REQ, then pulse rst_n mid-sequence.
- sw_time_group is unchanged until the next REQ entry.
- After reset: sw_req=0, table reads 0.

Source files
------------

// File: rtl/sw_seq_pkg.sv
// Shared definitions for the switch-timing sequencer.
//   seq_state_t : sequencer FSM states
//   N_SW        : switches per time group
//   SW_TW       : width of one switch-off time field
//   GROUP_W     : width of a full time group (N_SW * SW_TW)
//   GAP_MIN     : smallest permitted request-low gap between steps
//   clamp_gap() : effective gap length for a requested GAP_CYCLES
package sw_seq_pkg;

  localparam int N_SW    = 24;
  localparam int SW_TW   = 14;
  localparam int GROUP_W = 336;
  localparam int GAP_MIN = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  function automatic int clamp_gap(input int g);
    return (g < GAP_MIN) ? GAP_MIN : g;
  endfunction

endpackage

// File: rtl/sw_seq_if.sv
// Handshake bundle between the sequencer and the switch driver.
//   sw_time_group : 24 x 14-bit switch-off times, slot i at [14i+13:14i]
//   sw_req        : level request, held while the driver is working
//   sw_ack        : one-cycle completion pulse from the driver
// master = sequencer side, slave = switch-driver side.
interface sw_seq_if;
  import sw_seq_pkg::*;

  logic [GROUP_W-1:0] sw_time_group;
  logic               sw_req;
  logic               sw_ack;

  modport master (
    output sw_time_group,
    output sw_req,
    input  sw_ack
  );

  modport slave (
    input  sw_time_group,
    input  sw_req,
    output sw_ack
  );
endinterface

// File: rtl/sw_time_table.sv
// Profile storage: N_PROFILE time groups of N_SW x SW_TW entries.
//   clk, rst_n  : clock, asynchronous active-low reset (clears all entries)
//   i_wr_en     : write strobe; writes to slots >= N_SW are dropped
//   i_wr_prof   : profile to write
//   i_wr_slot   : slot within the profile
//   i_wr_data   : switch-off time to store
//   i_rd_prof   : profile to read
//   o_rd_group  : combinational read of the whole selected profile
module sw_time_table
  import sw_seq_pkg::*;
#(
  parameter int N_PROFILE = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr_en,
  input  logic [$clog2(N_PROFILE)-1:0] i_wr_prof,
  input  logic [4:0]                   i_wr_slot,
  input  logic [SW_TW-1:0]             i_wr_data,
  input  logic [$clog2(N_PROFILE)-1:0] i_rd_prof,
  output logic [GROUP_W-1:0]           o_rd_group
);
  localparam int PW = $clog2(N_PROFILE);

  logic               w_wr_ok;
  logic [GROUP_W-1:0] w_prof [N_PROFILE];

  assign w_wr_ok = i_wr_en && (i_wr_slot < 5'(N_SW));

  // One packed register per profile so each has its own reset/write logic.
  for (genvar gi = 0; gi < N_PROFILE; gi++) begin : g_prof
    logic [GROUP_W-1:0] r_prof;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prof <= '0;
      end else if (w_wr_ok && (i_wr_prof == PW'(gi))) begin
        r_prof[i_wr_slot*SW_TW +: SW_TW] <= i_wr_data;
      end
    end

    assign w_prof[gi] = r_prof;
  end

  assign o_rd_group = w_prof[i_rd_prof];

endmodule

// File: rtl/sw_sequencer.sv
// Steps a switch driver through up to N_PROFILE stored time groups per trigger.
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : arm; triggers ignored (and counted) while low
//   trig            : sequence start pulse
//   cfg_num_steps   : steps per sequence (0 -> 1, clamped to N_PROFILE)
//   cfg_wr_en/addr/data : table write port, addr = {profile, slot}
//   sw_if           : master side of the driver handshake (group, req, ack)
//   busy            : high whenever not IDLE
//   step_idx        : profile currently driven
//   seq_done        : one-cycle pulse on normal completion
//   err_timeout     : sticky ack-timeout flag
//   trig_miss_cnt   : saturating count of dropped triggers
module sw_sequencer
  import sw_seq_pkg::*;
#(
  parameter int N_PROFILE   = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1048576
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         trig,
  input  logic [$clog2(N_PROFILE):0]   cfg_num_steps,
  input  logic                         cfg_wr_en,
  input  logic [$clog2(N_PROFILE)+4:0] cfg_wr_addr,
  input  logic [SW_TW-1:0]             cfg_wr_data,
  sw_seq_if.master                     sw_if,
  output logic                         busy,
  output logic [$clog2(N_PROFILE)-1:0] step_idx,
  output logic                         seq_done,
  output logic                         err_timeout,
  output logic [15:0]                  trig_miss_cnt
);
  localparam int PW      = $clog2(N_PROFILE);
  localparam int GAP_EFF = clamp_gap(GAP_CYCLES);
  localparam int GW      = $clog2(GAP_EFF + 1);
  localparam int TW      = $clog2(ACK_TIMEOUT + 1);

  seq_state_t         r_state;
  seq_state_t         w_state_next;
  logic [PW-1:0]      r_step_idx;
  logic [GW-1:0]      r_gap_cnt;
  logic [TW-1:0]      r_to_cnt;
  logic               r_aborted;
  logic               r_seq_done;
  logic               r_err_timeout;
  logic [15:0]        r_miss_cnt;
  logic [GROUP_W-1:0] r_group;

  logic               w_sw_req;
  logic               w_start;
  logic               w_ack_hit;
  logic               w_timeout;
  logic               w_gap_end;
  logic               w_more;
  logic               w_load;
  logic               w_miss;
  logic [PW:0]        w_steps_eff;
  logic [PW-1:0]      w_rd_prof;
  logic [GROUP_W-1:0] w_tbl_group;

  sw_time_table #(
    .N_PROFILE (N_PROFILE)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (cfg_wr_en),
    .i_wr_prof  (cfg_wr_addr[PW+4:5]),
    .i_wr_slot  (cfg_wr_addr[4:0]),
    .i_wr_data  (cfg_wr_data),
    .i_rd_prof  (w_rd_prof),
    .o_rd_group (w_tbl_group)
  );

  always_comb begin
    w_steps_eff = cfg_num_steps;
    if (cfg_num_steps == '0) begin
      w_steps_eff = (PW+1)'(1);
    end else if (cfg_num_steps > (PW+1)'(N_PROFILE)) begin
      w_steps_eff = (PW+1)'(N_PROFILE);
    end
  end

  // A trigger landing on the seq_done cycle is treated as a miss even though
  // the FSM is already back in IDLE.
  assign w_start   = (r_state == IDLE) && trig && enable && !r_seq_done;
  assign w_ack_hit = (r_state == REQ) && sw_if.sw_ack;
  assign w_timeout = (r_state == REQ) && !sw_if.sw_ack && (r_to_cnt == TW'(ACK_TIMEOUT - 1));
  assign w_gap_end = (r_state == GAP) && (r_gap_cnt == GW'(GAP_EFF - 1));
  assign w_more    = (({1'b0, r_step_idx} + (PW+1)'(1)) < w_steps_eff) && enable && !r_aborted;
  assign w_load    = w_start || (w_gap_end && w_more);
  assign w_rd_prof = (r_state == IDLE) ? '0 : r_step_idx + PW'(1);
  assign w_miss    = trig && (busy || !enable || r_seq_done);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = REQ;
      REQ:     if (w_ack_hit || w_timeout) w_state_next = GAP;
      GAP:     if (w_gap_end) w_state_next = w_more ? REQ : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_sw_req = (r_state == REQ);
    busy     = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_idx    <= '0;
      r_gap_cnt     <= '0;
      r_to_cnt      <= '0;
      r_aborted     <= 1'b0;
      r_seq_done    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_miss_cnt    <= '0;
      r_group       <= '0;
    end else begin
      if (w_start) begin
        r_step_idx <= '0;
      end else if (w_gap_end && w_more) begin
        r_step_idx <= r_step_idx + PW'(1);
      end

      // Counters rest at zero outside their state so each entry starts fresh.
      if (r_state == GAP && !w_gap_end) begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end else begin
        r_gap_cnt <= '0;
      end

      if (r_state == REQ && !w_ack_hit && !w_timeout) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
        r_to_cnt <= '0;
      end

      // A timed-out sequence finishes its gap, then ends silently.
      if (w_start) begin
        r_aborted <= 1'b0;
      end else if (w_timeout) begin
        r_aborted <= 1'b1;
      end

      r_seq_done <= w_gap_end && !w_more && !r_aborted;

      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end

      if (w_miss && (r_miss_cnt != 16'hFFFF)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end

      // Latched only on REQ entry so table writes never disturb a live step.
      if (w_load) begin
        r_group <= w_tbl_group;
      end
    end
  end

  assign sw_if.sw_req        = w_sw_req;
  assign sw_if.sw_time_group = r_group;
  assign step_idx            = r_step_idx;
  assign seq_done            = r_seq_done;
  assign err_timeout         = r_err_timeout;
  assign trig_miss_cnt       = r_miss_cnt;

endmodule

// File: tb/tb_sw_sequencer.sv
module tb_sw_sequencer;
  localparam int NP  = 4;
  localparam int GAP = 4;
  localparam int ATO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        trig = 1'b0;
  logic [2:0]  cfg_num_steps = 3'd0;
  logic        cfg_wr_en = 1'b0;
  logic [6:0]  cfg_wr_addr = 7'd0;
  logic [13:0] cfg_wr_data = 14'd0;
  logic        busy;
  logic [1:0]  step_idx;
  logic        seq_done;
  logic        err_timeout;
  logic [15:0] trig_miss_cnt;

  sw_seq_if u_if ();

  sw_sequencer #(
    .N_PROFILE   (NP),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (ATO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .trig          (trig),
    .cfg_num_steps (cfg_num_steps),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_data   (cfg_wr_data),
    .sw_if         (u_if),
    .busy          (busy),
    .step_idx      (step_idx),
    .seq_done      (seq_done),
    .err_timeout   (err_timeout),
    .trig_miss_cnt (trig_miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [13:0] tbl [NP][24];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_miss = 0;
  int exp_err = 0;
  int ack_dly [NP];
  int drop_at = -1;
  bit inj = 0;
  bit wr_in_req = 0;
  bit trig_on_done = 0;
  int seq_no = 0;

  task automatic chk(input string tag, input logic [335:0] got, input logic [335:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (seq_done === 1'b1) done_cnt++;
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [335:0] pack(input int p);
    logic [335:0] g;
    g = '0;
    for (int s = 0; s < 24; s++) g[s*14 +: 14] = tbl[p][s];
    return g;
  endfunction

  task automatic wr(input int p, input int slot, input logic [13:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = {2'(p), 5'(slot)};
    cfg_wr_data = d;
    tick();
    cfg_wr_en = 1'b0;
    if (slot < 24) tbl[p][slot] = d;
    $display("wr prof=%0d slot=%0d data=%0h", p, slot, d);
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < 24; s++) tbl[p][s] = '0;
    exp_miss = 0;
    exp_err  = 0;
  endtask

  // One sequence seen from the switch-driver side: every step must raise
  // sw_req with the right profile, every inter-step gap is GAP low cycles,
  // and the sequence ends GAP cycles after the last fall.
  task automatic run_seq(input int cfg);
    int eff, hi, lo, d0, slot;
    bit fin, to;
    logic [335:0] g_exp;
    logic [13:0] d;
    eff = (cfg == 0) ? 1 : ((cfg > NP) ? NP : cfg);
    d0  = done_cnt;
    fin = 0;
    to  = 0;
    cfg_num_steps = 3'(cfg);
    enable = 1'b1;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int k = 0; k < eff && !fin; k++) begin
      g_exp = pack(k);
      chk("req_on", u_if.sw_req, 1);
      chk("step_idx", step_idx, k);
      chk("group", u_if.sw_time_group, g_exp);
      if (ack_dly[k] < 0) begin
        hi = 1;
        while (u_if.sw_req && hi < 200) begin
          tick();
          if (u_if.sw_req) hi++;
        end
        chk("timeout_len", hi, ATO);
        exp_err = 1;
        to  = 1;
        fin = 1;
      end else begin
        for (int i = 0; i < ack_dly[k]; i++) begin
          if (inj && $urandom_range(0, 7) == 0) begin
            trig = 1'b1;
            exp_miss = sat(exp_miss + 1);
          end
          if (wr_in_req && i == 0) begin
            slot = $urandom_range(0, 23);
            d = 14'($urandom);
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = {2'(k), 5'(slot)};
            cfg_wr_data = d;
            tbl[k][slot] = d;
          end
          tick();
          trig = 1'b0;
          cfg_wr_en = 1'b0;
        end
        chk("req_hold", u_if.sw_req, 1);
        chk("group_hold", u_if.sw_time_group, g_exp);
        u_if.sw_ack = 1'b1;
        tick();
        u_if.sw_ack = 1'b0;
        chk("req_off", u_if.sw_req, 0);
        if (drop_at == k) enable = 1'b0;
        if (k == eff - 1 || !enable) fin = 1;
      end
      if (!fin) begin
        lo = 1;
        while (!u_if.sw_req && lo < 50) begin
          tick();
          if (!u_if.sw_req) lo++;
        end
        chk("gap_len", lo, GAP);
      end
    end
    repeat (GAP) tick();
    chk("seq_done", seq_done, to ? 0 : 1);
    chk("idle_busy", busy, 0);
    if (trig_on_done && !to) begin
      trig = 1'b1;
      exp_miss = sat(exp_miss + 1);
    end
    tick();
    trig = 1'b0;
    chk("done_1cyc", seq_done, 0);
    chk("no_restart", u_if.sw_req, 0);
    chk("done_cnt", done_cnt - d0, to ? 0 : 1);
    chk("miss_cnt", trig_miss_cnt, exp_miss);
    chk("err_timeout", err_timeout, exp_err);
    $display("seq %0d cfg=%0d steps=%0d timeout=%0d miss=%0d", seq_no, cfg, eff, to, exp_miss);
    seq_no++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    u_if.sw_ack = 1'b0;
    clear_model();
    for (int k = 0; k < NP; k++) ack_dly[k] = 3;

    // Reset state
    tick();
    tick();
    chk("rst_req", u_if.sw_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step_idx, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_miss", trig_miss_cnt, 0);
    chk("rst_group", u_if.sw_time_group, 0);
    rst_n = 1'b1;
    tick();

    // Single step, slot 5 of profile 0
    wr(0, 5, 14'h0123);
    ack_dly[0] = 10;
    run_seq(1);
    chk("slot5", u_if.sw_time_group[83:70], 14'h0123);

    // Three steps over three distinct profiles
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < 24; s += 3) wr(p, s, 14'(p * 1000 + s + 1));
    for (int k = 0; k < NP; k++) ack_dly[k] = 20;
    run_seq(3);

    // Randomized sequences with table traffic, enable drops and stray triggers
    inj = 1;
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < 6; w++)
        wr($urandom_range(0, NP - 1), $urandom_range(0, 31), 14'($urandom));
      for (int k = 0; k < NP; k++) ack_dly[k] = $urandom_range(0, 25);
      drop_at      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NP - 1) : -1;
      trig_on_done = $urandom_range(0, 1) != 0;
      wr_in_req    = $urandom_range(0, 1) != 0;
      run_seq($urandom_range(0, 7));
    end
    inj = 0;
    drop_at = -1;
    trig_on_done = 0;
    wr_in_req = 0;

    // Ack timeout ends the sequence without seq_done; flag stays set
    ack_dly[0] = -1;
    run_seq(2);
    ack_dly[0] = 5;
    run_seq(1);
    chk("err_sticky", err_timeout, 1);

    // Write the live profile during REQ, then reset mid-sequence
    wr_in_req = 1;
    ack_dly[0] = 6;
    run_seq(1);
    wr_in_req = 0;
    run_seq(1);
    cfg_num_steps = 3'd2;
    enable = 1'b1;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("pre_rst_req", u_if.sw_req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", u_if.sw_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_group", u_if.sw_time_group, 0);
    chk("arst_err", err_timeout, 0);
    chk("arst_miss", trig_miss_cnt, 0);
    n = done_cnt;
    tick();
    rst_n = 1'b1;
    clear_model();
    repeat (6) tick();
    chk("rst_no_done", done_cnt - n, 0);
    for (int k = 0; k < NP; k++) ack_dly[k] = 2;
    run_seq(4);

    // Busy triggers, then saturating disabled triggers
    cfg_num_steps = 3'd1;
    trig = 1'b1;
    tick();
    trig = 1'b1;
    repeat (3) begin
      tick();
      exp_miss = sat(exp_miss + 1);
    end
    trig = 1'b0;
    chk("miss_busy", trig_miss_cnt, exp_miss);
    u_if.sw_ack = 1'b1;
    tick();
    u_if.sw_ack = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("drain", busy, 0);
    repeat (2) tick();
    enable = 1'b0;
    trig = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      exp_miss = sat(exp_miss + 1);
      tick();
      if (i == 99) chk("miss_mid", trig_miss_cnt, exp_miss);
    end
    trig = 1'b0;
    tick();
    chk("miss_sat", trig_miss_cnt, 16'hFFFF);
    chk("dis_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
